// File: rtl/alu8_pkg.sv
// Shared types and instruction layout for the ALU8 operand-fetch/issue stage.
package alu8_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned REG_AW  = 3;
    localparam int unsigned INSTR_W = 12;
    localparam int unsigned FIELD_W = 3;

    localparam int unsigned OP_LSB  = 9;
    localparam int unsigned RD_LSB  = 6;
    localparam int unsigned RS1_LSB = 3;
    localparam int unsigned RS2_LSB = 0;

    typedef enum logic [FIELD_W-1:0] {
        OpAdd  = 3'd0,
        OpSub  = 3'd1,
        OpNot  = 3'd2,
        OpNand = 3'd3,
        OpNor  = 3'd4,
        OpAnd  = 3'd5,
        OpOr   = 3'd6,
        OpXor  = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StExec   = 2'd1,
        StResult = 2'd2
    } state_e;

    // Every instruction field (op, rd, rs1, rs2) is FIELD_W bits wide.
    function automatic logic [FIELD_W-1:0] instr_field(input logic [INSTR_W-1:0] instr,
                                                        input int unsigned lsb);
        return FIELD_W'(instr >> lsb);
    endfunction

endpackage

// File: rtl/ALU8.sv
// 8-bit combinational ALU driven by the issue stage; all arithmetic wraps modulo 256.
module ALU8
    import alu8_pkg::*;
(
    input  logic [DATA_W-1:0]  a,
    input  logic [DATA_W-1:0]  b,
    input  logic [FIELD_W-1:0] op,
    output logic [DATA_W-1:0]  r
);

    always_comb begin
        r = '0;
        case (op)
            OpAdd:  r = a + b;
            OpSub:  r = a - b;
            OpNot:  r = ~a;
            OpNand: r = ~(a & b);
            OpNor:  r = ~(a | b);
            OpAnd:  r = a & b;
            OpOr:   r = a | b;
            OpXor:  r = a ^ b;
            default: r = '0;
        endcase
    end

endmodule

// File: rtl/alu8_instr_fifo.sv
// Instruction FIFO with count-based full/empty; no same-cycle pass-through.
module alu8_instr_fifo #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned INSTR_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [INSTR_W-1:0] din,
    output logic [INSTR_W-1:0] dout,
    output logic               full,
    output logic               empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [INSTR_W-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]    count_q, count_d;
    logic               push_en, pop_en;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu8_issue.sv
// Operand-fetch/issue stage: FIFO-fed instructions read the register file, drive the ALU
// from registers, and the captured result is written back and offered downstream.
module alu8_issue
    import alu8_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned NREGS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               wr_en,
    input  logic [REG_AW-1:0]  wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [FIELD_W-1:0] alu_op,
    input  logic [DATA_W-1:0]  alu_r,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [REG_AW-1:0]  out_rd,
    output logic               out_zero
);

    logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [INSTR_W-1:0] fifo_dout;
    logic               issue;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  regs_q [NREGS];
    logic [DATA_W-1:0]  regs_d [NREGS];
    logic [DATA_W-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [FIELD_W-1:0] alu_op_q, alu_op_d;
    logic [REG_AW-1:0]  rd_q, rd_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic [REG_AW-1:0]  out_rd_q, out_rd_d;
    logic               out_zero_q, out_zero_d;

    assign in_ready  = !fifo_full && !rst;
    assign fifo_push = in_valid && in_ready;

    alu8_instr_fifo #(
        .DEPTH  (DEPTH),
        .INSTR_W(INSTR_W)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (fifo_push),
        .pop  (fifo_pop),
        .din  (in_instr),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        regs_d      = regs_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rd_d        = rd_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_rd_d    = out_rd_q;
        out_zero_d  = out_zero_q;
        issue       = 1'b0;

        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
        end

        case (state_q)
            StIdle: begin
                issue = !fifo_empty;
            end
            StExec: begin
                out_data_d   = alu_r;
                out_zero_d   = (alu_r == '0);
                out_rd_d     = rd_q;
                regs_d[rd_q] = alu_r;  // overrides a same-edge host load
                out_valid_d  = 1'b1;
                state_d      = StResult;
            end
            StResult: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    issue       = !fifo_empty;
                    if (fifo_empty) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Operands come from regs_q, so a same-edge host load is not seen by this issue.
        if (issue) begin
            alu_a_d  = regs_q[instr_field(fifo_dout, RS1_LSB)];
            alu_b_d  = regs_q[instr_field(fifo_dout, RS2_LSB)];
            alu_op_d = instr_field(fifo_dout, OP_LSB);
            rd_d     = instr_field(fifo_dout, RD_LSB);
            state_d  = StExec;
        end
        fifo_pop = issue;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rd_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            regs_q      <= regs_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rd_q        <= rd_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_rd_q    <= out_rd_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_rd    = out_rd_q;
    assign out_zero  = out_zero_q;

endmodule

// File: doc/alu8_issue.md
# alu8_issue

Operand-fetch and issue stage placed directly upstream of the 8-bit combinational ALU (`ALU8`).
- Accepts 12-bit register-to-register instructions through a valid/ready FIFO.
- Reads two operands from an internal 8x8 register file and drives the ALU's A/B/Op inputs from registers.
- Captures the ALU result one cycle later, writes it back to the register file and presents it downstream with a zero flag under valid/ready.

## Interface
Parameters:
- DEPTH, 4, instruction FIFO entries (power of two, ≥2)
- NREGS, 8, register-file entries (address width 3)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  instruction offered
- in_ready  out  1  FIFO can accept; `!full`, forced 0 while rst high
- in_instr  in  12  [11:9] op, [8:6] rd, [5:3] rs1, [2:0] rs2
- wr_en  in  1  host register load
- wr_addr  in  3  host load address
- wr_data  in  8  host load data
- alu_a  out  8  registered operand A to ALU
- alu_b  out  8  registered operand B to ALU
- alu_op  out  3  registered opcode to ALU
- alu_r  in  8  ALU result (combinational from alu_a/alu_b/alu_op)
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_data  out  8  captured result
- out_rd  out  3  destination register of result
- out_zero  out  1  out_data == 0

## Operation
- **FIFO:**
  - Push on `in_valid && in_ready`.
  - Pop only in ISSUE as below; no same-cycle pass-through, so an entry pushed at edge E is poppable at E+1 at the earliest.
  - Pointers wrap modulo DEPTH.
  - Full/empty are tracked with a count, or with one extra pointer bit.
- **FSM states:** IDLE, EXEC, RESULT.
  - **IDLE:** if FIFO non-empty, pop the head and register `alu_a=regs[rs1]`, `alu_b=regs[rs2]`, `alu_op=op`; go to EXEC.
  - **EXEC:** unconditionally capture `out_data=alu_r`, `out_zero=(alu_r==0)`, `out_rd=rd`; write `regs[rd]=alu_r`; set `out_valid=1`; go to RESULT.
  - **RESULT:** hold all outputs while `out_ready=0`.
    - On `out_ready=1`, clear `out_valid`.
    - In that same edge, if FIFO is non-empty, pop and issue the next instruction (go to EXEC); otherwise go to IDLE.
- **Opcode handling:** rs2 is read for every op, including NOT (op 2); the ALU ignores it.
- **Arithmetic:** all arithmetic is 8-bit modulo, computed in the ALU. This block adds no carry or overflow.
- **Host load:** `wr_en` writes `regs[wr_addr]=wr_data` at the edge.
  - If it coincides with an EXEC writeback to the same address, the ALU writeback wins.
  - An issue in the same edge reads the pre-edge value.
- **Hazards:** writeback (EXEC) always precedes the next issue by ≥1 edge, so dependent instructions see updated registers without forwarding.
- **Reset (any time, including mid-operation):**
  - FIFO emptied, state IDLE, all `regs=0`.
  - `alu_a`, `alu_b`, `alu_op`, `out_data`, `out_rd` = 0.
  - `out_zero=0`, `out_valid=0`, `in_ready=0`.
  - In-flight instructions are discarded.
  - After deassertion: `in_ready=1`.

## Timing
- Instruction pushed into an empty FIFO at edge E0:
  - issued (alu_* valid) after E1;
  - `out_valid=1` after E2.
- Sustained throughput: one result per 2 cycles when `out_ready=1`.
- Backpressure: with `out_ready=0`, the block accepts DEPTH+1 instructions (one held in RESULT, DEPTH in FIFO); `in_ready` then stays 0.
- Outputs are registered except `in_ready`, which is combinational from the FIFO count and rst.
- No combinational path from `in_valid` or `out_ready` to any output.

## Structure
- Package `alu8_pkg` holds:
  - opcode enum: ADD=0, SUB=1, NOT=2, NAND=3, NOR=4, AND=5, OR=6, XOR=7;
  - instruction field bit positions;
  - DATA_W=8, REG_AW=3, INSTR_W=12;
  - FSM state typedef.
- Sub-module `alu8_instr_fifo` (parameterised DEPTH, INSTR_W; push/pop/full/empty).
- Register file and FSM live in the top level.
- Bench instantiates `ALU8` alongside and wires `alu_*` to it.

## Test plan
- Reset, host loads r1=0x05 and r2=0x03, then ADD rd=3 rs1=1 rs2=2 → `out_valid` rises 2 edges after accept; `out_data=0x08`, `out_rd=3`, `out_zero=0`.
- SUB r1-r1 → `out_data=0x00`, `out_zero=1`; SUB r2-r1 → `out_data=0xFE` (wrap).
- Dependent chain back-to-back (ADD r3=r1+r2, XOR r4=r3^r1) with `out_ready=1` → second result 0x0D, results spaced exactly 2 cycles.
- Hold `out_ready=0` and offer 6 instructions → exactly 5 accepted, `in_ready=0`; release → 5 results in order, FIFO empties, state IDLE.
- EXEC writeback and `wr_en` to the same rd in the same edge → register holds the ALU value. Also: host write to rs1 on the issue edge → old operand used.
- Assert rst while in EXEC with 3 entries queued → `out_valid=0` immediately, no further results after deassert, all registers read back 0.
